// File: rtl/scan_chain_loader.sv
// Host-side scan chain loader: serialises command bytes onto the scan chain
// LSB first and returns the displaced chain bits as readback bytes.
module scan_chain_loader #(
    parameter int CHAIN_LEN = 24,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    input  logic       run_req,
    output logic       processor_enable,
    output logic       scan_enable,
    output logic       scan_in,
    input  logic       scan_out,
    output logic       frame_active
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SHIFT    = 2'd1;
    localparam logic [1:0] ST_RSP      = 2'd2;
    localparam logic [1:0] ST_WAIT_CMD = 2'd3;

    localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(CHAIN_LEN);

    logic [1:0]       state_q, state_d;
    logic [7:0]       tx_q, tx_d;
    logic [7:0]       rx_q, rx_d;
    logic [3:0]       bcnt_q, bcnt_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        bcnt_d  = bcnt_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            ST_IDLE, ST_WAIT_CMD: begin
                if (cmd_valid) begin
                    tx_d    = cmd_data;
                    rx_d    = 8'h00;
                    bcnt_d  = 4'd0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                tx_d = {1'b0, tx_q[7:1]};
                // Indexed capture keeps a short final byte right-aligned.
                rx_d[bcnt_q[2:0]] = scan_out;
                bcnt_d = bcnt_q + 4'd1;
                fcnt_d = fcnt_q + 1'b1;
                if (bcnt_d == 4'd8 || fcnt_d == FRAME_END) begin
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    if (fcnt_q == FRAME_END) begin
                        fcnt_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_CMD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            tx_q    <= 8'h00;
            rx_q    <= 8'h00;
            bcnt_q  <= 4'd0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            bcnt_q  <= bcnt_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Outputs are gated by rst so everything reads 0 while reset is held.
    assign cmd_ready        = rst && (state_q == ST_IDLE || state_q == ST_WAIT_CMD);
    assign rsp_valid        = rst && (state_q == ST_RSP);
    assign rsp_data         = (rst && state_q == ST_RSP) ? rx_q : 8'h00;
    assign scan_enable      = rst && (state_q == ST_SHIFT);
    assign scan_in          = rst && (state_q == ST_SHIFT) && tx_q[0];
    assign processor_enable = rst && run_req && (state_q == ST_IDLE);
    assign frame_active     = rst && (state_q != ST_IDLE);

endmodule
